// File: rtl/systolic_feeder_pkg.sv
// Package shared by the systolic feeder, its delay lines and the PE array.
// Holds the datapath defaults, the feeder state encoding and a helper that
// sizes the flush down-counter.
package systolic_feeder_pkg;

  // Datapath defaults shared with the PE row (Q6.10 signed operands).
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_N     = 4;
  localparam int unsigned FRAC_BIT  = 10;

  // Feeder state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // The flush counter must hold N-1. Keep it at least one bit wide so the
  // N=1 build still has a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register carrying a data word and a
// valid bit. The whole chain advances only when en_i is high and is cleared
// by the synchronous active-high reset.
//   clk, rst          clock, synchronous reset
//   en_i              advance enable (low = freeze every stage)
//   data_i, valid_i   word and flag entering stage 0
//   data_o, valid_o   word and flag leaving the last stage
module skew_delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (en_i) begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: turns a stream of N-element vectors into the skewed
// a-operand wavefront for a row of N PEs. Lane k sees element k delayed by
// k extra cycles. After the last vector of a matrix the lanes run out with
// bubbles and done pulses once the final operand has left lane N-1.
//
// Handshake: a vector is taken on a rising edge where s_valid && s_ready.
// s_ready never depends on s_valid; s_data/s_last only matter when s_valid
// is high. hold freezes lanes, state and counter and drops s_ready.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   upstream vector stream
//   hold             array stall
//   a_out, a_valid   skewed operands and per-lane valids to the PE row
//   busy             high in FEED or FLUSH
//   done             one-cycle pulse at the end of a matrix
//   dbg_state        current FSM state, for observation only
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             hold,
  output logic [N*WIDTH-1:0] a_out,
  output logic [N-1:0]     a_valid,
  output logic             busy,
  output logic             done,
  output feeder_state_e    dbg_state
);

  localparam int unsigned   CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  feeder_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // rst is folded in so s_ready and done stay low during the reset cycle.
  assign s_ready   = !rst && !hold && (state_q == ST_IDLE || state_q == ST_FEED);
  assign accept    = s_valid && s_ready;
  assign busy      = (state_q == ST_FEED) || (state_q == ST_FLUSH);
  assign done      = !rst && !hold && (state_q == ST_DONE);
  assign dbg_state = state_q;

  // FLUSH is entered on the edge where the last vector enters the lanes.
  // The counter starts at N-1, so it reaches 0 exactly in the cycle where
  // that vector's last element sits on lane N-1. hold freezes lanes and
  // counter together, so this alignment survives stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (!hold) begin
      case (state_q)
        ST_IDLE, ST_FEED: begin
          if (accept) begin
            if (s_last) begin
              state_q <= ST_FLUSH;
              cnt_q   <= CNT_LOAD;
            end else begin
              state_q <= ST_FEED;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // One delay line per lane; lane k is k+1 stages deep. Cycles without an
  // accept push a zero bubble so idle lanes always present a_out = 0.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [WIDTH-1:0] lane_din;
    assign lane_din = accept ? s_data[k*WIDTH +: WIDTH] : '0;

    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(k + 1)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (!hold),
      .data_i (lane_din),
      .valid_i(accept),
      .data_o (a_out[k*WIDTH +: WIDTH]),
      .valid_o(a_valid[k])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: cycle tables for the N=4 instance, a per-lane
// expected queue fed at every accept and drained as elements leave the
// lanes, plus hand sequences for mid-operation reset and an N=1 instance.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int W  = 16;
  localparam int NL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N=4 instance ----------------
  logic [NL*W-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic            hold = 1'b0;
  logic [NL*W-1:0] a_out;
  logic [NL-1:0]   a_valid;
  logic            busy, done;
  feeder_state_e   dbg_state;

  systolic_feeder #(.WIDTH(W), .N(NL)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .hold(hold), .a_out(a_out), .a_valid(a_valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- N=1 instance ----------------
  logic [W-1:0]  s1_data = '0;
  logic          s1_valid = 1'b0;
  logic          s1_last = 1'b0;
  logic          s1_ready;
  logic          hold1 = 1'b0;
  logic [W-1:0]  a1_out;
  logic [0:0]    a1_valid;
  logic          busy1, done1;
  feeder_state_e dbg_state1;

  systolic_feeder #(.WIDTH(W), .N(1)) dut1 (
    .clk(clk), .rst(rst), .s_data(s1_data), .s_valid(s1_valid), .s_last(s1_last),
    .s_ready(s1_ready), .hold(hold1), .a_out(a1_out), .a_valid(a1_valid),
    .busy(busy1), .done(done1), .dbg_state(dbg_state1)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ln(input logic [15:0] l0, input logic [15:0] l1,
                                     input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [NL][$];
  logic         held_edge = 1'b0;

  // Every accepted vector queues its elements per lane.
  always @(posedge clk) begin
    held_edge <= hold;
    if (!rst && s_valid && s_ready) begin
      for (int k = 0; k < NL; k++) exp_q[k].push_back(s_data[k*W +: W]);
    end
  end

  // A lane output is new only if the preceding edge was not frozen.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NL; k++) exp_q[k].delete();
    end else if (!held_edge) begin
      for (int k = 0; k < NL; k++) begin
        if (a_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("sb_extra_lane%0d", k), 64'(a_out[k*W +: W]), 64'hDEAD);
          end else begin
            check($sformatf("sb_lane%0d", k), 64'(a_out[k*W +: W]), 64'(exp_q[k].pop_front()));
          end
        end else begin
          check($sformatf("sb_bubble_lane%0d", k), 64'(a_out[k*W +: W]), 64'h0);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        sv, sl, hd;
    logic [63:0] din;
    logic [3:0]  av;
    logic [63:0] aout;
    logic        rdy, bsy, dn;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic sv, input logic sl, input logic hd, input logic [63:0] din,
                     input logic [3:0] av, input logic [63:0] aout,
                     input logic rdy, input logic bsy, input logic dn);
    vec_t v;
    v.sv = sv; v.sl = sl; v.hd = hd; v.din = din;
    v.av = av; v.aout = aout; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic sv, input logic sl, input logic hd, input logic [63:0] d);
    s_valid = sv; s_last = sl; hold = hd; s_data = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] z, s, v2, v3, b, e;
    z  = 64'h0;
    s  = ln(1, 2, 3, 4);
    v2 = ln(11, 12, 13, 14);
    v3 = ln(21, 22, 23, 24);
    b  = ln(31, 32, 33, 34);
    e  = ln(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);

    // single vector
    add(1,1,0, s, 4'b0000, z,               1,0,0);
    add(0,0,0, z, 4'b0001, ln(1,0,0,0),     0,1,0);
    add(0,0,0, z, 4'b0010, ln(0,2,0,0),     0,1,0);
    add(0,0,0, z, 4'b0100, ln(0,0,3,0),     0,1,0);
    add(0,0,0, z, 4'b1000, ln(0,0,0,4),     0,1,0);
    add(0,0,0, z, 4'b0000, z,               0,0,1);
    add(0,0,0, z, 4'b0000, z,               1,0,0);
    // streaming, last on the third
    add(1,0,0, s,  4'b0000, z,              1,0,0);
    add(1,0,0, v2, 4'b0001, ln(1,0,0,0),    1,1,0);
    add(1,1,0, v3, 4'b0011, ln(11,2,0,0),   1,1,0);
    add(0,0,0, z,  4'b0111, ln(21,12,3,0),  0,1,0);
    add(0,0,0, z,  4'b1110, ln(0,22,13,4),  0,1,0);
    add(0,0,0, z,  4'b1100, ln(0,0,23,14),  0,1,0);
    add(0,0,0, z,  4'b1000, ln(0,0,0,24),   0,1,0);
    add(0,0,0, z,  4'b0000, z,              0,0,1);
    add(0,0,0, z,  4'b0000, z,              1,0,0);
    // 2-cycle gap; s_last without s_valid is ignored
    add(1,0,0, s, 4'b0000, z,               1,0,0);
    add(0,1,0, z, 4'b0001, ln(1,0,0,0),     1,1,0);
    add(0,1,0, z, 4'b0010, ln(0,2,0,0),     1,1,0);
    add(1,1,0, b, 4'b0100, ln(0,0,3,0),     1,1,0);
    add(0,0,0, z, 4'b1001, ln(31,0,0,4),    0,1,0);
    add(0,0,0, z, 4'b0010, ln(0,32,0,0),    0,1,0);
    add(0,0,0, z, 4'b0100, ln(0,0,33,0),    0,1,0);
    add(0,0,0, z, 4'b1000, ln(0,0,0,34),    0,1,0);
    add(0,0,0, z, 4'b0000, z,               0,0,1);
    add(0,0,0, z, 4'b0000, z,               1,0,0);
    // hold: first in IDLE (no accept), then 3 cycles while lane2 shows 3
    add(1,1,1, s, 4'b0000, z,               0,0,0);
    add(1,1,0, s, 4'b0000, z,               1,0,0);
    add(0,0,0, z, 4'b0001, ln(1,0,0,0),     0,1,0);
    add(0,0,0, z, 4'b0010, ln(0,2,0,0),     0,1,0);
    add(0,0,1, z, 4'b0100, ln(0,0,3,0),     0,1,0);
    add(0,0,1, z, 4'b0100, ln(0,0,3,0),     0,1,0);
    add(0,0,1, z, 4'b0100, ln(0,0,3,0),     0,1,0);
    add(0,0,0, z, 4'b0100, ln(0,0,3,0),     0,1,0);
    add(0,0,0, z, 4'b1000, ln(0,0,0,4),     0,1,0);
    add(0,0,0, z, 4'b0000, z,               0,0,1);
    add(0,0,0, z, 4'b0000, z,               1,0,0);
    // extreme values
    add(1,1,0, e, 4'b0000, z,                     1,0,0);
    add(0,0,0, z, 4'b0001, ln(16'h8000,0,0,0),    0,1,0);
    add(0,0,0, z, 4'b0010, ln(0,16'h7FFF,0,0),    0,1,0);
    add(0,0,0, z, 4'b0100, ln(0,0,16'h8000,0),    0,1,0);
    add(0,0,0, z, 4'b1000, ln(0,0,0,16'h7FFF),    0,1,0);
    add(0,0,0, z, 4'b0000, z,                     0,0,1);
    add(0,0,0, z, 4'b0000, z,                     1,0,0);

    // reset, then the first cycle after rst drops
    drive(0,0,0,z);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_valid", 64'(a_valid), 64'h0);
    check("rst_a_out", a_out, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_ready", 64'(s_ready), 64'h1);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    next_cycle();

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sv, tbl[i].sl, tbl[i].hd, tbl[i].din);
      @(negedge clk);
      check($sformatf("r%0d_a_valid", i), 64'(a_valid), 64'(tbl[i].av));
      check($sformatf("r%0d_a_out", i), a_out, tbl[i].aout);
      check($sformatf("r%0d_ready", i), 64'(s_ready), 64'(tbl[i].rdy));
      check($sformatf("r%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
      check($sformatf("r%0d_done", i), 64'(done), 64'(tbl[i].dn));
      next_cycle();
    end

    // reset in the middle of FEED with lanes loaded
    drive(1,0,0,s);
    @(negedge clk);
    next_cycle();
    drive(1,0,0,v2);
    @(negedge clk);
    next_cycle();
    drive(0,0,0,z);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_loaded", 64'(a_valid), 64'h3);
    check("mrst_ready_in_rst", 64'(s_ready), 64'h0);
    next_cycle();
    @(negedge clk);
    check("mrst_a_valid", 64'(a_valid), 64'h0);
    check("mrst_a_out", a_out, 64'h0);
    check("mrst_busy", 64'(busy), 64'h0);
    check("mrst_done", 64'(done), 64'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready_after", 64'(s_ready), 64'h1);
    check("mrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mrst_done_after", 64'(done), 64'h0);
    next_cycle();

    // N=1: element out one cycle after accept, done the cycle after that
    s1_valid = 1'b1; s1_last = 1'b1; s1_data = 16'h8000;
    @(negedge clk);
    check("n1_ready_idle", 64'(s1_ready), 64'h1);
    next_cycle();
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
    @(negedge clk);
    check("n1_a_valid", 64'(a1_valid), 64'h1);
    check("n1_a_out", 64'(a1_out), 64'h8000);
    check("n1_busy", 64'(busy1), 64'h1);
    check("n1_done_early", 64'(done1), 64'h0);
    check("n1_ready_flush", 64'(s1_ready), 64'h0);
    next_cycle();
    @(negedge clk);
    check("n1_done", 64'(done1), 64'h1);
    check("n1_a_valid_off", 64'(a1_valid), 64'h0);
    next_cycle();
    @(negedge clk);
    check("n1_done_once", 64'(done1), 64'h0);
    check("n1_ready_back", 64'(s1_ready), 64'h1);
    next_cycle();

    // every queued element must have come out
    for (int k = 0; k < NL; k++) begin
      check($sformatf("sb_drain_lane%0d", k), 64'(exp_q[k].size()), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
